// File: rtl/global_defs.sv
// ---------------------------------------------------------------------------
// global_defs.sv
// Shared build-wide constants and the k-NN result entry type.
//   `K          : depth of the top-K buffer
//   `DIST_WIDTH : width of a distance value; all ones marks an empty slot
//   knn_entry_t : {distance, valid}, one slot of the top-K buffer
// ---------------------------------------------------------------------------
`ifndef GLOBAL_DEFS_SV
`define GLOBAL_DEFS_SV

`ifndef K
`define K 4
`endif

`ifndef DIST_WIDTH
`define DIST_WIDTH 16
`endif

package knn_defs_pkg;
  typedef struct packed {
    logic [`DIST_WIDTH-1:0] distance;
    logic                   valid;
  } knn_entry_t;
endpackage

`endif

// File: rtl/knn_result_drain.sv
// ---------------------------------------------------------------------------
// knn_result_drain
// Snapshots the sorted top-K buffer on a start pulse and streams its entries
// out one per cycle over a valid/ready port, nearest first.
//
// Ports
//   clk            : clock, all state on the rising edge
//   reset          : asynchronous, active-low
//   start          : one-cycle request to drain the current buffer (IDLE only)
//   flush          : synchronous abort back to IDLE, no done pulse
//   knn_buffer_in  : sorted ascending top-K buffer (empty slots at the tail)
//   threshold_in   : current top-K threshold, captured at start
//   out_valid      : out_entry/out_index/out_last are presented
//   out_ready      : downstream accepts the presented entry
//   out_entry      : current entry
//   out_index      : rank of out_entry, 0 = nearest
//   out_last       : out_entry is the final entry of this drain
//   out_threshold  : threshold captured at the accepted start
//   busy           : high while in SEND or DONE
//   done           : one-cycle completion pulse
//   dbg_state      : current FSM state (0 IDLE, 1 SEND, 2 DONE)
//
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid=1 and out_ready=0 the entry,
// index and last flag hold stable; out_valid never drops without a transfer
// except on flush or reset.
// ---------------------------------------------------------------------------
module knn_result_drain
  import knn_defs_pkg::*;
#(
  parameter bit DROP_EMPTY = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   flush,
  input  knn_entry_t [`K-1:0]    knn_buffer_in,
  input  logic [`DIST_WIDTH-1:0] threshold_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output knn_entry_t             out_entry,
  output logic [$clog2(`K)-1:0]  out_index,
  output logic                   out_last,
  output logic [`DIST_WIDTH-1:0] out_threshold,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  localparam int K  = `K;
  localparam int IW = $clog2(`K);
  localparam int NW = $clog2(`K + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  knn_entry_t r_snap [K];
  logic [NW-1:0] r_n;

  logic [NW-1:0] w_n;
  logic [IW-1:0] w_next_idx;
  logic          w_next_last;

  // Number of entries to emit. Because the buffer is sorted ascending, all
  // empty slots sit at the tail, so the count is the position of the first
  // empty slot; nothing after it needs to be visited.
  always_comb begin
    w_n = NW'(K);
    if (DROP_EMPTY) begin
      for (int i = K - 1; i >= 0; i--) begin
        if (knn_buffer_in[i].distance == '1) begin
          w_n = NW'(i);
        end
      end
    end
  end

  // Next index wraps only past the last slot, which is never used as a next
  // entry because that transfer ends the drain.
  assign w_next_idx  = out_index + 1'b1;
  assign w_next_last = (NW'(w_next_idx) == (r_n - NW'(1)));

  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_n           <= '0;
      out_valid     <= 1'b0;
      out_entry     <= '0;
      out_index     <= '0;
      out_last      <= 1'b0;
      out_threshold <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int i = 0; i < K; i++) begin
        r_snap[i] <= '0;
      end
    end else if (flush) begin
      // Abort wins over start and over a transfer on the same edge.
      r_state   <= S_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < K; i++) begin
              r_snap[i] <= knn_buffer_in[i];
            end
            out_threshold <= threshold_in;
            r_n           <= w_n;
            out_index     <= '0;
            busy          <= 1'b1;
            if (w_n != '0) begin
              // First entry comes straight from the input so it is valid the
              // cycle after the start edge.
              r_state   <= S_SEND;
              out_valid <= 1'b1;
              out_entry <= knn_buffer_in[0];
              out_last  <= (w_n == NW'(1));
            end else begin
              r_state   <= S_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (out_ready) begin
            if (out_last) begin
              r_state   <= S_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_index <= w_next_idx;
              out_entry <= r_snap[w_next_idx];
              out_last  <= w_next_last;
            end
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          r_state <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_result_drain.sv
// ---------------------------------------------------------------------------
// tb_knn_result_drain
// Self-checking bench for knn_result_drain (K=4, DIST_WIDTH=16,
// DROP_EMPTY=1). Expected entries are queued when a drain is started and
// popped by a monitor whenever a transfer is about to happen.
// ---------------------------------------------------------------------------
module tb_knn_result_drain;
  import knn_defs_pkg::*;

  localparam int IW = $clog2(`K);
  localparam int EW = 1 + IW + `DIST_WIDTH + 1;
  localparam logic [`DIST_WIDTH-1:0] INF = '1;

  logic                   clk;
  logic                   reset;
  logic                   start;
  logic                   flush;
  knn_entry_t [`K-1:0]    buf_in;
  logic [`DIST_WIDTH-1:0] thr_in;
  logic                   out_valid;
  logic                   out_ready;
  knn_entry_t             out_entry;
  logic [IW-1:0]          out_index;
  logic                   out_last;
  logic [`DIST_WIDTH-1:0] out_threshold;
  logic                   busy;
  logic                   done;
  logic [1:0]             dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  knn_result_drain #(.DROP_EMPTY(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .flush         (flush),
    .knn_buffer_in (buf_in),
    .threshold_in  (thr_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_entry     (out_entry),
    .out_index     (out_index),
    .out_last      (out_last),
    .out_threshold (out_threshold),
    .busy          (busy),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transfer monitor: sampled mid-cycle, a transfer happens on the next edge.
  always @(negedge clk) begin
    if (reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_xfer", 32'(exp_q.size()), 32'd1);
      end else begin
        check("xfer", 32'({out_last, out_index, out_entry.distance, out_entry.valid}),
              32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_entry(input int i, input logic [`DIST_WIDTH-1:0] d, input logic v);
    buf_in[i].distance = d;
    buf_in[i].valid    = v;
  endtask

  // Queue the first n_push entries of a drain of n_total entries.
  task automatic push_drain(input int n_total, input int n_push);
    for (int i = 0; i < n_push; i++) begin
      exp_q.push_back({(i == n_total - 1), IW'(i), buf_in[i].distance, buf_in[i].valid});
    end
  endtask

  // Returns one tick after the edge that samples start.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen.
  task automatic wait_done(input bit rnd, output int cyc);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
    out_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int cyc;
  int n;
  logic [`DIST_WIDTH-1:0] d;

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; out_ready = 1'b1;
    buf_in = '0; thr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_index", 32'(out_index), 0);
    check("rst_entry", 32'(out_entry), 0);
    check("rst_thr", 32'(out_threshold), 0);
    check("rst_state", 32'(dbg_state), 0);
    #2 reset = 1'b1;

    // Full buffer, ready high.
    set_entry(0, 5, 1); set_entry(1, 10, 1); set_entry(2, 20, 1); set_entry(3, 30, 1);
    thr_in = 30;
    push_drain(4, 4);
    pulse_start();
    check("full_first_valid", 32'(out_valid), 1);
    check("full_first_idx", 32'(out_index), 0);
    wait_done(1'b0, cyc);
    check("full_latency", 32'(cyc), 4);
    check("full_thr", 32'(out_threshold), 30);
    check("full_q_empty", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    check("full_done_1cyc", 32'(done), 0);
    check("full_busy_off", 32'(busy), 0);

    // One real entry followed by empty slots; valid=0 passes through.
    set_entry(0, 60, 0); set_entry(1, INF, 1); set_entry(2, INF, 1); set_entry(3, INF, 1);
    thr_in = 77;
    push_drain(1, 1);
    pulse_start();
    check("part_last", 32'(out_last), 1);
    wait_done(1'b0, cyc);
    check("part_latency", 32'(cyc), 1);
    check("part_thr", 32'(out_threshold), 77);
    // start during the DONE cycle is ignored.
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_in_done_busy", 32'(busy), 0);
    check("start_in_done_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("start_in_done_idle", 32'(dbg_state), 0);

    // All empty: done straight after the start edge.
    for (int i = 0; i < `K; i++) set_entry(i, INF, 1);
    thr_in = 12;
    pulse_start();
    check("empty_no_valid", 32'(out_valid), 0);
    check("empty_done", 32'(done), 1);
    wait_done(1'b0, cyc);
    check("empty_latency", 32'(cyc), 0);
    check("empty_thr", 32'(out_threshold), 12);
    @(posedge clk); #1;

    // Backpressure at index 1, buffer rewritten and start pulsed mid-drain.
    set_entry(0, 5, 1); set_entry(1, 10, 1); set_entry(2, 20, 1); set_entry(3, 60, 1);
    thr_in = 99;
    push_drain(4, 4);
    pulse_start();
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < `K; i++) set_entry(i, 16'(1000 + i), 0);
    thr_in = 3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 start = 1'b0;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_index", 32'(out_index), 1);
      check("bp_dist", 32'(out_entry.distance), 10);
    end
    out_ready = 1'b1;
    wait_done(1'b0, cyc);
    check("bp_q_empty", 32'(exp_q.size()), 0);
    check("bp_thr", 32'(out_threshold), 99);
    @(posedge clk); #1;
    check("bp_no_restart", 32'(busy), 0);

    // Flush at index 2 with ready high.
    set_entry(0, 5, 1); set_entry(1, 10, 1); set_entry(2, 20, 1); set_entry(3, 60, 1);
    push_drain(4, 2);
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("flush_at_idx2", 32'(out_index), 2);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_valid", 32'(out_valid), 0);
    check("flush_busy", 32'(busy), 0);
    check("flush_idle", 32'(dbg_state), 0);
    for (int i = 0; i < 3; i++) begin
      check("flush_no_done", 32'(done), 0);
      @(posedge clk); #1;
    end
    check("flush_q_empty", 32'(exp_q.size()), 0);
    push_drain(4, 4);
    pulse_start();
    check("flush_restart_idx", 32'(out_index), 0);
    wait_done(1'b0, cyc);
    check("flush_restart_latency", 32'(cyc), 4);
    @(posedge clk); #1;

    // Asynchronous reset mid-drain.
    thr_in = 44;
    push_drain(4, 1);
    pulse_start();
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_index", 32'(out_index), 0);
    check("arst_entry", 32'(out_entry), 0);
    check("arst_thr", 32'(out_threshold), 0);
    check("arst_last", 32'(out_last), 0);
    check("arst_q_empty", 32'(exp_q.size()), 0);
    @(posedge clk); #3 reset = 1'b1;
    check("arst_no_done", 32'(done), 0);
    push_drain(4, 4);
    pulse_start();
    wait_done(1'b0, cyc);
    check("arst_restart_latency", 32'(cyc), 4);
    check("arst_restart_thr", 32'(out_threshold), 44);
    @(posedge clk); #1;

    // Randomised drains with random backpressure.
    for (int t = 0; t < 20; t++) begin
      n = int'($urandom_range(0, `K));
      d = 16'($urandom_range(0, 50));
      for (int i = 0; i < `K; i++) begin
        if (i < n) begin
          set_entry(i, d, 1'($urandom_range(0, 1)));
          d = d + 16'($urandom_range(0, 50));
        end else begin
          set_entry(i, INF, 1'($urandom_range(0, 1)));
        end
      end
      thr_in = 16'($urandom_range(0, 65000));
      push_drain(n, n);
      pulse_start();
      wait_done(1'b1, cyc);
      check("rnd_latency_min", 32'(cyc >= n), 1);
      check("rnd_q_empty", 32'(exp_q.size()), 0);
      check("rnd_thr", 32'(out_threshold), 32'(thr_in));
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
